// File: rtl/mips_isa_pkg.sv
`default_nettype none
// ============================================================================
// mips_isa_pkg -- mnemonic codes, MIPS opcode/funct constants, loader states
// Rev 1.0
// ============================================================================
package mips_isa_pkg;

  typedef enum logic [4:0] {
    MN_ADD  = 5'd0,  MN_SUB  = 5'd1,  MN_AND  = 5'd2,  MN_OR   = 5'd3,
    MN_XOR  = 5'd4,  MN_NOR  = 5'd5,  MN_SLT  = 5'd6,  MN_SLL  = 5'd7,
    MN_SRL  = 5'd8,  MN_JR   = 5'd9,  MN_JALR = 5'd10, MN_J    = 5'd11,
    MN_JAL  = 5'd12, MN_BEQ  = 5'd13, MN_BNE  = 5'd14, MN_ADDI = 5'd15,
    MN_SLTI = 5'd16, MN_ANDI = 5'd17, MN_ORI  = 5'd18, MN_XORI = 5'd19,
    MN_LUI  = 5'd20, MN_LW   = 5'd21, MN_SW   = 5'd22
  } mnem_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_JR    = 6'd8;
  localparam logic [5:0] FN_JALR  = 6'd9;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_XOR   = 6'd38;
  localparam logic [5:0] FN_NOR   = 6'd39;
  localparam logic [5:0] FN_SLT   = 6'd42;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } load_state_e;

endpackage
`default_nettype wire

// File: rtl/inst_encoder_loader_if.sv
`default_nettype none
// ============================================================================
// inst_encoder_loader_if -- operand-bundle handshake and imem write port
// Rev 1.0
// ============================================================================
interface inst_encoder_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        mnem;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [15:0]       imm16;
  logic [25:0]       target;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, mnem, rs, rt, rd, shamt, imm16, target,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, mnem, rs, rt, rd, shamt, imm16, target,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/inst_field_packer.sv
`default_nettype none
// ============================================================================
// inst_field_packer -- combinational (mnem, fields) -> {32-bit MIPS word, illegal}
// Rev 1.0
// ============================================================================
module inst_field_packer
  import mips_isa_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm16,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Illegal codes fall through to an all-zero word, which is sll $0,$0,0.
  always_comb begin
    word    = 32'd0;
    illegal = 1'b0;
    case (mnem)
      MN_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      MN_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      MN_AND:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
      MN_OR:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
      MN_XOR:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_XOR};
      MN_NOR:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_NOR};
      MN_SLT:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
      MN_SLL:  word = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SLL};
      MN_SRL:  word = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SRL};
      MN_JR:   word = {OP_RTYPE, rs, 5'd0, 5'd0, 5'd0, FN_JR};
      MN_JALR: word = {OP_RTYPE, rs, 5'd0, rd, 5'd0, FN_JALR};
      MN_J:    word = {OP_J, target};
      MN_JAL:  word = {OP_JAL, target};
      MN_BEQ:  word = {OP_BEQ, rs, rt, imm16};
      MN_BNE:  word = {OP_BNE, rs, rt, imm16};
      MN_ADDI: word = {OP_ADDI, rs, rt, imm16};
      MN_SLTI: word = {OP_SLTI, rs, rt, imm16};
      MN_ANDI: word = {OP_ANDI, rs, rt, imm16};
      MN_ORI:  word = {OP_ORI, rs, rt, imm16};
      MN_XORI: word = {OP_XORI, rs, rt, imm16};
      MN_LUI:  word = {OP_LUI, 5'd0, rt, imm16};
      MN_LW:   word = {OP_LW, rs, rt, imm16};
      MN_SW:   word = {OP_SW, rs, rt, imm16};
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/inst_encoder_loader.sv
`default_nettype none
// ============================================================================
// inst_encoder_loader -- encodes mnemonic bundles and streams them into imem.
// Option macro: INST_ENC_ILLEGAL_TRAP_EN (trap illegal codes instead of nop).
// Rev 1.0
// ============================================================================
module inst_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [CNT_W-1:0]     count,
  inst_encoder_loader_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

`ifdef INST_ENC_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  load_state_e       state;
  load_state_e       state_nxt;
  logic [CNT_W-1:0]  remaining;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       pk_word;
  logic              pk_illegal;
  logic              accept;
  logic              write_en;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              err_q;

  inst_field_packer u_packer (
    .mnem    (bus.mnem),
    .rs      (bus.rs),
    .rt      (bus.rt),
    .rd      (bus.rd),
    .shamt   (bus.shamt),
    .imm16   (bus.imm16),
    .target  (bus.target),
    .word    (pk_word),
    .illegal (pk_illegal)
  );

  assign bus.in_ready  = (state == ST_LOAD) && (remaining != '0);
  assign accept        = bus.in_valid && bus.in_ready;
  // A trapped bundle still consumes a count slot but never reaches memory.
  assign write_en      = accept && !(TRAP_EN && pk_illegal);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign err           = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (count != '0) ? ST_LOAD : ST_DONE;
        end
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (accept && (remaining == CNT_W'(1))) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        busy      = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining   <= '0;
      wr_addr     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q <= write_en;
      if ((state == ST_IDLE) && start) begin
        remaining <= count;
        wr_addr   <= base_addr;
        err_q     <= 1'b0;
      end
      if (accept) begin
        remaining <= remaining - CNT_W'(1);
      end
      if (write_en) begin
        wr_addr     <= wr_addr + ADDR_W'(1);
        mem_addr_q  <= wr_addr;
        mem_wdata_q <= pk_word;
      end
      if (accept && pk_illegal && TRAP_EN) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder_loader.sv
`default_nettype none
// tb_inst_encoder_loader -- directed and randomized loads checked against a
// field-level MIPS encoding model and an address/latency scoreboard.
module tb_inst_encoder_loader;

`ifdef INST_ENC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] base_addr = '0;
  logic [9:0] count = '0;
  logic       busy, done, err;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  inst_encoder_loader_if bus ();

  inst_encoder_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Opcode per mnemonic and funct per R-format mnemonic (codes 0..10).
  int op_tab [23] = '{0,0,0,0,0,0,0,0,0,0,0,2,3,4,5,8,10,12,13,14,15,35,43};
  int fn_tab [11] = '{32,34,36,37,38,39,42,0,2,8,9};

  function automatic logic [31:0] ref_enc(int m, int rs, int rt, int rd, int sh, int imm, int tg);
    logic [31:0] w;
    if (m > 22) return 32'd0;
    w = 32'(op_tab[m]) << 26;
    if (m <= 6)       w |= 32'((rs << 21) | (rt << 16) | (rd << 11) | fn_tab[m]);
    else if (m <= 8)  w |= 32'((rt << 16) | (rd << 11) | (sh << 6) | fn_tab[m]);
    else if (m == 9)  w |= 32'((rs << 21) | fn_tab[m]);
    else if (m == 10) w |= 32'((rs << 21) | (rd << 11) | fn_tab[m]);
    else if (m <= 12) w |= 32'(tg);
    else if (m == 20) w |= 32'((rt << 16) | imm);
    else              w |= 32'((rs << 21) | (rt << 16) | imm);
    return w;
  endfunction

  logic [9:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_acc[$];
  logic [9:0]  obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];
  int          acc_cyc[$];
  int          done_cyc[$];
  logic [9:0]  model_addr;
  int          n_sent;
  logic        exp_err;
  int          start_cyc;

  always @(negedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
    if (bus.mem_we) begin
      obs_addr.push_back(bus.mem_addr);
      obs_data.push_back(bus.mem_wdata);
      obs_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
  end

  task automatic do_start(input int base, input int cnt);
    exp_addr.delete(); exp_data.delete(); exp_acc.delete();
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    acc_cyc.delete(); done_cyc.delete();
    model_addr = 10'(base);
    n_sent     = 0;
    exp_err    = 1'b0;
    start      = 1'b1;
    base_addr  = 10'(base);
    count      = 10'(cnt);
    start_cyc  = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int m, input int rs, input int rt, input int rd,
                      input int sh, input int imm, input int tg, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    bus.mnem = 5'(m); bus.rs = 5'(rs); bus.rt = 5'(rt); bus.rd = 5'(rd);
    bus.shamt = 5'(sh); bus.imm16 = 16'(imm); bus.target = 26'(tg);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (m > 22 && TRAP) exp_err = 1'b1;
    else begin
      exp_addr.push_back(model_addr);
      exp_data.push_back(ref_enc(m, rs, rt, rd, sh, imm, tg));
      exp_acc.push_back(n_sent);
      model_addr = model_addr + 10'd1;
    end
    n_sent++;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && done_cyc.size() == 0; i++) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic send_random();
    int m;
    m = ($urandom_range(0, 9) == 0) ? int'($urandom_range(23, 31)) : int'($urandom_range(0, 22));
    send(m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
         $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 67108863),
         $urandom_range(0, 2));
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    total++; if (bus.mem_addr !== 10'd0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 32'd0) begin bad++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
    total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_status: got busy/done/err=%b want 000", {busy, done, err}); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_program();
    int tb_base [2] = '{16, 32};
    int tm [6]  = '{15, 0, 22, 11, 10, 20};
    int trs [6] = '{0, 8, 0, 0, 31, 7};
    int trt [6] = '{8, 8, 9, 0, 0, 1};
    int trd [6] = '{0, 9, 0, 0, 2, 0};
    int tim [6] = '{5, 0, 4, 0, 0, 4660};
    int ttg [6] = '{0, 0, 0, 64, 0, 0};
    int want_cyc, got_done, want_done;
    for (int l = 0; l < 2; l++) begin
      do_start(tb_base[l], 3);
      for (int b = 0; b < 3; b++)
        send(tm[l*3+b], trs[l*3+b], trt[l*3+b], trd[l*3+b], 0, tim[l*3+b], ttg[l*3+b], 0);
      wait_done();
      total++;
      if (obs_addr.size() != exp_addr.size()) begin bad++; $display("FAIL prog%0d_count: got %0d writes want %0d", l, obs_addr.size(), exp_addr.size()); end
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
        want_cyc = (exp_acc[i] < acc_cyc.size()) ? acc_cyc[exp_acc[i]] + 1 : -1;
        total++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_cyc[i] != want_cyc) begin
          bad++; $display("FAIL prog%0d_write%0d: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d", l, i, obs_addr[i], obs_data[i], obs_cyc[i], exp_addr[i], exp_data[i], want_cyc);
        end
      end
      got_done  = (done_cyc.size() > 0) ? done_cyc[0] : -1;
      want_done = (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size()-1] + 2 : -2;
      total++;
      if (done_cyc.size() != 1 || got_done != want_done) begin bad++; $display("FAIL prog%0d_done: got %0d pulses at %0d want 1 at %0d", l, done_cyc.size(), got_done, want_done); end
    end
  endtask

  task automatic test_count_zero();
    int dd;
    do_start(5, 0);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    dd = (done_cyc.size() > 0) ? done_cyc[0] - start_cyc : -1;
    total++; if (obs_addr.size() != 0) begin bad++; $display("FAIL zero_writes: got %0d writes want 0", obs_addr.size()); end
    total++; if (done_cyc.size() != 1 || dd < 1 || dd > 2) begin bad++; $display("FAIL zero_done: got %0d pulses, delay %0d want 1 pulse 1..2 cycles after start", done_cyc.size(), dd); end
  endtask

  task automatic test_illegal();
    int want_cyc, got_done, want_done;
    do_start(64, 3);
    send(15, 1, 2, 0, 0, 100, 0, 0);
    send(25, 3, 4, 5, 6, 7, 8, 0);
    send(18, 2, 3, 0, 0, 16'hBEEF, 0, 0);
    wait_done();
    total++;
    if (obs_addr.size() != exp_addr.size()) begin bad++; $display("FAIL illegal_count: got %0d writes want %0d", obs_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      want_cyc = (exp_acc[i] < acc_cyc.size()) ? acc_cyc[exp_acc[i]] + 1 : -1;
      total++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_cyc[i] != want_cyc) begin
        bad++; $display("FAIL illegal_write%0d: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d", i, obs_addr[i], obs_data[i], obs_cyc[i], exp_addr[i], exp_data[i], want_cyc);
      end
    end
    got_done  = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    want_done = (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size()-1] + 2 : -2;
    total++; if (done_cyc.size() != 1 || got_done != want_done) begin bad++; $display("FAIL illegal_done: got %0d pulses at %0d want 1 at %0d", done_cyc.size(), got_done, want_done); end
    total++; if (err !== exp_err) begin bad++; $display("FAIL illegal_err: got %b want %b", err, exp_err); end
  endtask

  task automatic test_wrap();
    int want_cyc, got_done, want_done;
    do_start(1023, 2);
    @(negedge clk);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL wrap_err_cleared: got %b want 0", err); end
    @(posedge clk); #1;
    send(21, 4, 5, 0, 0, 12, 0, 1);
    send(0, 1, 2, 3, 0, 0, 0, 1);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL wrap_ready_drop: got in_ready=%b busy=%b want 0 1", bus.in_ready, busy); end
    wait_done();
    total++;
    if (obs_addr.size() != exp_addr.size()) begin bad++; $display("FAIL wrap_count: got %0d writes want %0d", obs_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      want_cyc = (exp_acc[i] < acc_cyc.size()) ? acc_cyc[exp_acc[i]] + 1 : -1;
      total++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_cyc[i] != want_cyc) begin
        bad++; $display("FAIL wrap_write%0d: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d", i, obs_addr[i], obs_data[i], obs_cyc[i], exp_addr[i], exp_data[i], want_cyc);
      end
    end
    got_done  = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    want_done = (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size()-1] + 2 : -2;
    total++; if (done_cyc.size() != 1 || got_done != want_done) begin bad++; $display("FAIL wrap_done: got %0d pulses at %0d want 1 at %0d", done_cyc.size(), got_done, want_done); end
  endtask

  task automatic test_abort();
    int want_cyc, got_done, want_done;
    do_start(256, 4);
    send(15, 0, 8, 0, 0, 5, 0, 0);
    rst = 1'b1;
    bus.mnem = 5'd0; bus.rs = 5'd1; bus.rt = 5'd2; bus.rd = 5'd3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.in_ready, bus.mem_we, busy, done, err} !== 5'b0 || bus.mem_addr !== 10'd0 || bus.mem_wdata !== 32'd0) begin
      bad++; $display("FAIL abort_outputs: got rdy/we/busy/done/err=%b addr=%h data=%h want all 0", {bus.in_ready, bus.mem_we, busy, done, err}, bus.mem_addr, bus.mem_wdata);
    end
    repeat (3) @(negedge clk);
    total++;
    if (obs_addr.size() != 1 || obs_data.size() != 1 || obs_data[0] !== 32'h2008_0005) begin
      bad++; $display("FAIL abort_writes: got %0d writes want 1 (first word only)", obs_addr.size());
    end
    @(posedge clk); #1;
    do_start(512, 2);
    send(16, 9, 10, 0, 0, 65535, 0, 0);
    send(7, 0, 11, 12, 13, 0, 0, 0);
    wait_done();
    total++;
    if (obs_addr.size() != exp_addr.size()) begin bad++; $display("FAIL restart_count: got %0d writes want %0d", obs_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      want_cyc = (exp_acc[i] < acc_cyc.size()) ? acc_cyc[exp_acc[i]] + 1 : -1;
      total++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_cyc[i] != want_cyc) begin
        bad++; $display("FAIL restart_write%0d: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d", i, obs_addr[i], obs_data[i], obs_cyc[i], exp_addr[i], exp_data[i], want_cyc);
      end
    end
    got_done  = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    want_done = (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size()-1] + 2 : -2;
    total++; if (done_cyc.size() != 1 || got_done != want_done) begin bad++; $display("FAIL restart_done: got %0d pulses at %0d want 1 at %0d", done_cyc.size(), got_done, want_done); end
  endtask

  task automatic test_random();
    int n, want_cyc, got_done, want_done;
    for (int l = 0; l < 8; l++) begin
      n = $urandom_range(1, 8);
      do_start($urandom_range(0, 1023), n);
      for (int b = 0; b < n; b++) send_random();
      wait_done();
      total++;
      if (obs_addr.size() != exp_addr.size()) begin bad++; $display("FAIL rand%0d_count: got %0d writes want %0d", l, obs_addr.size(), exp_addr.size()); end
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
        want_cyc = (exp_acc[i] < acc_cyc.size()) ? acc_cyc[exp_acc[i]] + 1 : -1;
        total++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_cyc[i] != want_cyc) begin
          bad++; $display("FAIL rand%0d_write%0d: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d", l, i, obs_addr[i], obs_data[i], obs_cyc[i], exp_addr[i], exp_data[i], want_cyc);
        end
      end
      got_done  = (done_cyc.size() > 0) ? done_cyc[0] : -1;
      want_done = (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size()-1] + 2 : -2;
      total++; if (done_cyc.size() != 1 || got_done != want_done) begin bad++; $display("FAIL rand%0d_done: got %0d pulses at %0d want 1 at %0d", l, done_cyc.size(), got_done, want_done); end
      total++; if (err !== exp_err) begin bad++; $display("FAIL rand%0d_err: got %b want %b", l, err, exp_err); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.mnem = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0;
    bus.shamt = '0; bus.imm16 = '0; bus.target = '0;
    test_reset();
    test_program();
    test_count_zero();
    test_illegal();
    test_wrap();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
